// File: rtl/pipeline_fanout.sv
// Broadcasts one accepted sample to effect pipelines A and B, collects both results
// (or silence on timeout) and presents them to the mixer as a one-cycle valid pair.
module pipeline_fanout #(
  parameter int data_width     = 16,
  parameter int timeout_cycles = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [data_width-1:0] in_sample,
  input  logic                  in_sample_valid,
  input  logic                  active_a,
  input  logic                  active_b,
  output logic [data_width-1:0] pipe_sample,
  output logic                  pipe_a_start,
  output logic                  pipe_b_start,
  input  logic [data_width-1:0] pipe_a_result,
  input  logic                  pipe_a_done,
  input  logic [data_width-1:0] pipe_b_result,
  input  logic                  pipe_b_done,
  output logic [data_width-1:0] out_sample_a,
  output logic [data_width-1:0] out_sample_b,
  output logic                  out_samples_valid,
  output logic                  busy,
  output logic                  timeout_a,
  output logic                  timeout_b,
  output logic                  overrun,
  input  logic                  clear_flags
);

  // state      | meaning
  // st_idle    | waiting for in_sample_valid
  // st_wait    | starts issued, collecting pipeline results (busy)
  // st_present | out_samples_valid high; a new sample may be accepted here
  typedef enum logic [1:0] {
    st_idle,
    st_wait,
    st_present
  } state_t;

  state_t state, state_nxt;

  logic                  act_a, act_b, act_a_nxt, act_b_nxt;
  logic                  got_a, got_b, got_a_nxt, got_b_nxt;
  logic [data_width-1:0] res_a, res_b, res_a_nxt, res_b_nxt;
  logic [15:0]           cnt, cnt_nxt;
  logic [data_width-1:0] pipe_sample_nxt;
  logic                  pipe_a_start_nxt, pipe_b_start_nxt;
  logic [data_width-1:0] out_sample_a_nxt, out_sample_b_nxt;
  logic                  out_samples_valid_nxt, busy_nxt;
  logic                  timeout_a_nxt, timeout_b_nxt, overrun_nxt;

  logic                  cap_a, cap_b, have_a, have_b;
  logic [data_width-1:0] val_a, val_b;

  // First done from an active pipe wins; later or inactive dones are ignored.
  assign cap_a  = act_a & ~got_a & pipe_a_done;
  assign cap_b  = act_b & ~got_b & pipe_b_done;
  assign have_a = ~act_a | got_a | cap_a;
  assign have_b = ~act_b | got_b | cap_b;
  assign val_a  = cap_a ? pipe_a_result : res_a;
  assign val_b  = cap_b ? pipe_b_result : res_b;

  always_comb begin
    state_nxt             = state;
    act_a_nxt             = act_a;
    act_b_nxt             = act_b;
    got_a_nxt             = got_a;
    got_b_nxt             = got_b;
    res_a_nxt             = res_a;
    res_b_nxt             = res_b;
    cnt_nxt               = cnt;
    pipe_sample_nxt       = pipe_sample;
    pipe_a_start_nxt      = 1'b0;
    pipe_b_start_nxt      = 1'b0;
    out_sample_a_nxt      = out_sample_a;
    out_sample_b_nxt      = out_sample_b;
    out_samples_valid_nxt = 1'b0;
    timeout_a_nxt         = clear_flags ? 1'b0 : timeout_a;
    timeout_b_nxt         = clear_flags ? 1'b0 : timeout_b;
    overrun_nxt           = clear_flags ? 1'b0 : overrun;

    case (state)
      st_idle, st_present: begin
        state_nxt = st_idle;
        if (in_sample_valid) begin
          pipe_sample_nxt = in_sample;
          act_a_nxt       = active_a;
          act_b_nxt       = active_b;
          if (active_a || active_b) begin
            pipe_a_start_nxt = active_a;
            pipe_b_start_nxt = active_b;
            got_a_nxt        = 1'b0;
            got_b_nxt        = 1'b0;
            // Down-counter: reaches zero in the last allowed WAIT cycle.
            cnt_nxt          = 16'(timeout_cycles);
            state_nxt        = st_wait;
          end else begin
            out_sample_a_nxt      = '0;
            out_sample_b_nxt      = '0;
            out_samples_valid_nxt = 1'b1;
          end
        end
      end

      st_wait: begin
        if (in_sample_valid) overrun_nxt = 1'b1;
        if (cap_a) begin
          res_a_nxt = pipe_a_result;
          got_a_nxt = 1'b1;
        end
        if (cap_b) begin
          res_b_nxt = pipe_b_result;
          got_b_nxt = 1'b1;
        end
        if ((have_a && have_b) || cnt == '0) begin
          out_sample_a_nxt      = (act_a && have_a) ? val_a : '0;
          out_sample_b_nxt      = (act_b && have_b) ? val_b : '0;
          if (act_a && !have_a) timeout_a_nxt = 1'b1;
          if (act_b && !have_b) timeout_b_nxt = 1'b1;
          out_samples_valid_nxt = 1'b1;
          state_nxt             = st_present;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end

      default: state_nxt = st_idle;
    endcase

    busy_nxt = (state_nxt == st_wait);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= st_idle;
      act_a             <= 1'b0;
      act_b             <= 1'b0;
      got_a             <= 1'b0;
      got_b             <= 1'b0;
      res_a             <= '0;
      res_b             <= '0;
      cnt               <= '0;
      pipe_sample       <= '0;
      pipe_a_start      <= 1'b0;
      pipe_b_start      <= 1'b0;
      out_sample_a      <= '0;
      out_sample_b      <= '0;
      out_samples_valid <= 1'b0;
      busy              <= 1'b0;
      timeout_a         <= 1'b0;
      timeout_b         <= 1'b0;
      overrun           <= 1'b0;
    end else begin
      state             <= state_nxt;
      act_a             <= act_a_nxt;
      act_b             <= act_b_nxt;
      got_a             <= got_a_nxt;
      got_b             <= got_b_nxt;
      res_a             <= res_a_nxt;
      res_b             <= res_b_nxt;
      cnt               <= cnt_nxt;
      pipe_sample       <= pipe_sample_nxt;
      pipe_a_start      <= pipe_a_start_nxt;
      pipe_b_start      <= pipe_b_start_nxt;
      out_sample_a      <= out_sample_a_nxt;
      out_sample_b      <= out_sample_b_nxt;
      out_samples_valid <= out_samples_valid_nxt;
      busy              <= busy_nxt;
      timeout_a         <= timeout_a_nxt;
      timeout_b         <= timeout_b_nxt;
      overrun           <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_pipeline_fanout.sv
// Directed bench for pipeline_fanout; cycle k of each scenario is k cycles after acceptance.
module tb_pipeline_fanout;

  localparam int DW = 16;

  logic          clk;
  logic          reset;
  logic [DW-1:0] in_sample;
  logic          in_sample_valid;
  logic          active_a, active_b;
  logic [DW-1:0] pipe_sample;
  logic          pipe_a_start, pipe_b_start;
  logic [DW-1:0] pipe_a_result, pipe_b_result;
  logic          pipe_a_done, pipe_b_done;
  logic [DW-1:0] out_sample_a, out_sample_b;
  logic          out_samples_valid, busy;
  logic          timeout_a, timeout_b, overrun;
  logic          clear_flags;

  int n_checks;
  int n_fail;

  pipeline_fanout #(.data_width(DW), .timeout_cycles(8)) dut (
    .clk(clk), .reset(reset),
    .in_sample(in_sample), .in_sample_valid(in_sample_valid),
    .active_a(active_a), .active_b(active_b),
    .pipe_sample(pipe_sample),
    .pipe_a_start(pipe_a_start), .pipe_b_start(pipe_b_start),
    .pipe_a_result(pipe_a_result), .pipe_a_done(pipe_a_done),
    .pipe_b_result(pipe_b_result), .pipe_b_done(pipe_b_done),
    .out_sample_a(out_sample_a), .out_sample_b(out_sample_b),
    .out_samples_valid(out_samples_valid), .busy(busy),
    .timeout_a(timeout_a), .timeout_b(timeout_b), .overrun(overrun),
    .clear_flags(clear_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_sample_valid = 1'b0;
    in_sample       = '0;
    active_a        = 1'b0;
    active_b        = 1'b0;
    pipe_a_done     = 1'b0;
    pipe_b_done     = 1'b0;
    pipe_a_result   = '0;
    pipe_b_result   = '0;
    clear_flags     = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    n_checks += 4;
    if ({busy, out_samples_valid, pipe_a_start, pipe_b_start, timeout_a, timeout_b, overrun} !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctrl got %b exp 0", {busy, out_samples_valid, pipe_a_start, pipe_b_start, timeout_a, timeout_b, overrun});
    end
    if (pipe_sample !== 16'h0) begin n_fail++; $display("FAIL reset_pipe_sample got %h exp 0000", pipe_sample); end
    if (out_sample_a !== 16'h0) begin n_fail++; $display("FAIL reset_out_a got %h exp 0000", out_sample_a); end
    if (out_sample_b !== 16'h0) begin n_fail++; $display("FAIL reset_out_b got %h exp 0000", out_sample_b); end
    step();
    step();
    reset = 1'b0;
    step();
    n_checks++;
    if ({busy, out_samples_valid, pipe_a_start, pipe_b_start} !== 4'b0) begin
      n_fail++; $display("FAIL reset_release got %b exp 0000", {busy, out_samples_valid, pipe_a_start, pipe_b_start});
    end
  endtask

  task automatic test_both_active();
    for (int k = 0; k <= 7; k++) begin
      in_sample_valid = (k == 0);
      in_sample       = 16'h0800;
      active_a        = 1'b1;
      active_b        = 1'b1;
      pipe_a_done     = (k == 3);
      pipe_a_result   = (k == 3) ? 16'h1234 : 16'hdead;
      pipe_b_done     = (k == 5);
      pipe_b_result   = (k == 5) ? 16'hfedc : 16'hbeef;
      n_checks += 4;
      if (pipe_a_start !== (k == 1)) begin n_fail++; $display("FAIL both_start_a k=%0d got %b exp %b", k, pipe_a_start, (k == 1)); end
      if (pipe_b_start !== (k == 1)) begin n_fail++; $display("FAIL both_start_b k=%0d got %b exp %b", k, pipe_b_start, (k == 1)); end
      if (busy !== (k >= 1 && k <= 5)) begin n_fail++; $display("FAIL both_busy k=%0d got %b exp %b", k, busy, (k >= 1 && k <= 5)); end
      if (out_samples_valid !== (k == 6)) begin n_fail++; $display("FAIL both_valid k=%0d got %b exp %b", k, out_samples_valid, (k == 6)); end
      if (k == 6) begin
        n_checks += 3;
        if (out_sample_a !== 16'h1234) begin n_fail++; $display("FAIL both_out_a got %h exp 1234", out_sample_a); end
        if (out_sample_b !== 16'hfedc) begin n_fail++; $display("FAIL both_out_b got %h exp fedc", out_sample_b); end
        if (pipe_sample !== 16'h0800) begin n_fail++; $display("FAIL both_pipe_sample got %h exp 0800", pipe_sample); end
      end
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_a_only();
    for (int k = 0; k <= 6; k++) begin
      in_sample_valid = (k == 0);
      in_sample       = 16'h0123;
      active_a        = (k == 0);
      active_b        = 1'b0;
      pipe_b_done     = (k == 2);
      pipe_b_result   = 16'h7fff;
      pipe_a_done     = (k == 4);
      pipe_a_result   = (k == 4) ? 16'h0100 : 16'h5a5a;
      n_checks += 3;
      if (pipe_a_start !== (k == 1)) begin n_fail++; $display("FAIL aonly_start_a k=%0d got %b exp %b", k, pipe_a_start, (k == 1)); end
      if (pipe_b_start !== 1'b0) begin n_fail++; $display("FAIL aonly_start_b k=%0d got %b exp 0", k, pipe_b_start); end
      if (out_samples_valid !== (k == 5)) begin n_fail++; $display("FAIL aonly_valid k=%0d got %b exp %b", k, out_samples_valid, (k == 5)); end
      if (k == 5) begin
        n_checks += 2;
        if (out_sample_a !== 16'h0100) begin n_fail++; $display("FAIL aonly_out_a got %h exp 0100", out_sample_a); end
        if (out_sample_b !== 16'h0000) begin n_fail++; $display("FAIL aonly_out_b got %h exp 0000", out_sample_b); end
      end
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_timeout();
    for (int k = 0; k <= 12; k++) begin
      in_sample_valid = (k == 0);
      in_sample       = 16'h0300;
      active_a        = 1'b1;
      active_b        = 1'b1;
      pipe_a_done     = (k == 2);
      pipe_a_result   = 16'h0042;
      pipe_b_done     = 1'b0;
      clear_flags     = (k == 9);
      n_checks += 4;
      if (busy !== (k >= 1 && k <= 9)) begin n_fail++; $display("FAIL tmo_busy k=%0d got %b exp %b", k, busy, (k >= 1 && k <= 9)); end
      if (out_samples_valid !== (k == 10)) begin n_fail++; $display("FAIL tmo_valid k=%0d got %b exp %b", k, out_samples_valid, (k == 10)); end
      if (timeout_b !== (k >= 10)) begin n_fail++; $display("FAIL tmo_flag_b k=%0d got %b exp %b", k, timeout_b, (k >= 10)); end
      if (timeout_a !== 1'b0) begin n_fail++; $display("FAIL tmo_flag_a k=%0d got %b exp 0", k, timeout_a); end
      if (k == 10) begin
        n_checks += 2;
        if (out_sample_a !== 16'h0042) begin n_fail++; $display("FAIL tmo_out_a got %h exp 0042", out_sample_a); end
        if (out_sample_b !== 16'h0000) begin n_fail++; $display("FAIL tmo_out_b got %h exp 0000", out_sample_b); end
      end
      step();
    end
    idle_inputs();
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    n_checks++;
    if (timeout_b !== 1'b0) begin n_fail++; $display("FAIL tmo_clear got %b exp 0", timeout_b); end
    step();
    for (int k = 0; k <= 11; k++) begin
      in_sample_valid = (k == 0);
      in_sample       = 16'h0301;
      active_a        = 1'b1;
      active_b        = 1'b1;
      pipe_a_done     = (k == 1);
      pipe_a_result   = 16'h0043;
      pipe_b_done     = (k == 9);
      pipe_b_result   = (k == 9) ? 16'h5555 : 16'haaaa;
      n_checks += 3;
      if (busy !== (k >= 1 && k <= 9)) begin n_fail++; $display("FAIL edge_busy k=%0d got %b exp %b", k, busy, (k >= 1 && k <= 9)); end
      if (out_samples_valid !== (k == 10)) begin n_fail++; $display("FAIL edge_valid k=%0d got %b exp %b", k, out_samples_valid, (k == 10)); end
      if (timeout_b !== 1'b0) begin n_fail++; $display("FAIL edge_flag_b k=%0d got %b exp 0", k, timeout_b); end
      if (k == 10) begin
        n_checks += 2;
        if (out_sample_a !== 16'h0043) begin n_fail++; $display("FAIL edge_out_a got %h exp 0043", out_sample_a); end
        if (out_sample_b !== 16'h5555) begin n_fail++; $display("FAIL edge_out_b got %h exp 5555", out_sample_b); end
      end
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_overrun();
    for (int k = 0; k <= 8; k++) begin
      in_sample_valid = (k == 0 || k == 3 || k == 5);
      in_sample       = (k == 0) ? 16'h0111 : (k == 3) ? 16'h0222 : (k == 5) ? 16'h0333 : 16'h0999;
      active_a        = 1'b1;
      active_b        = 1'b1;
      pipe_a_done     = (k == 2 || k == 3 || k == 6);
      pipe_a_result   = (k == 2) ? 16'h0aaa : (k == 3) ? 16'h0eee : 16'h0ccc;
      pipe_b_done     = (k == 4 || k == 6);
      pipe_b_result   = (k == 4) ? 16'h0bbb : 16'h0ddd;
      n_checks += 5;
      if (pipe_a_start !== (k == 1 || k == 6)) begin n_fail++; $display("FAIL ovr_start_a k=%0d got %b exp %b", k, pipe_a_start, (k == 1 || k == 6)); end
      if (pipe_b_start !== (k == 1 || k == 6)) begin n_fail++; $display("FAIL ovr_start_b k=%0d got %b exp %b", k, pipe_b_start, (k == 1 || k == 6)); end
      if (overrun !== (k >= 4)) begin n_fail++; $display("FAIL ovr_flag k=%0d got %b exp %b", k, overrun, (k >= 4)); end
      if (busy !== ((k >= 1 && k <= 4) || k == 6)) begin n_fail++; $display("FAIL ovr_busy k=%0d got %b exp %b", k, busy, ((k >= 1 && k <= 4) || k == 6)); end
      if (out_samples_valid !== (k == 5 || k == 7)) begin n_fail++; $display("FAIL ovr_valid k=%0d got %b exp %b", k, out_samples_valid, (k == 5 || k == 7)); end
      if (k >= 1 && k <= 5) begin
        n_checks++;
        if (pipe_sample !== 16'h0111) begin n_fail++; $display("FAIL ovr_pipe_sample k=%0d got %h exp 0111", k, pipe_sample); end
      end
      if (k == 5) begin
        n_checks += 2;
        if (out_sample_a !== 16'h0aaa) begin n_fail++; $display("FAIL ovr_out_a got %h exp 0aaa", out_sample_a); end
        if (out_sample_b !== 16'h0bbb) begin n_fail++; $display("FAIL ovr_out_b got %h exp 0bbb", out_sample_b); end
      end
      if (k == 6) begin
        n_checks++;
        if (pipe_sample !== 16'h0333) begin n_fail++; $display("FAIL ovr_next_sample got %h exp 0333", pipe_sample); end
      end
      if (k == 7) begin
        n_checks += 2;
        if (out_sample_a !== 16'h0ccc) begin n_fail++; $display("FAIL ovr_next_out_a got %h exp 0ccc", out_sample_a); end
        if (out_sample_b !== 16'h0ddd) begin n_fail++; $display("FAIL ovr_next_out_b got %h exp 0ddd", out_sample_b); end
      end
      step();
    end
    idle_inputs();
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got %b exp 0", overrun); end
    step();
  endtask

  task automatic test_none_active();
    for (int k = 0; k <= 2; k++) begin
      in_sample_valid = (k == 0);
      in_sample       = 16'h4444;
      active_a        = 1'b0;
      active_b        = 1'b0;
      n_checks += 3;
      if (out_samples_valid !== (k == 1)) begin n_fail++; $display("FAIL none_valid k=%0d got %b exp %b", k, out_samples_valid, (k == 1)); end
      if ({pipe_a_start, pipe_b_start} !== 2'b00) begin n_fail++; $display("FAIL none_starts k=%0d got %b exp 00", k, {pipe_a_start, pipe_b_start}); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL none_busy k=%0d got %b exp 0", k, busy); end
      if (k == 1) begin
        n_checks += 3;
        if (out_sample_a !== 16'h0000) begin n_fail++; $display("FAIL none_out_a got %h exp 0000", out_sample_a); end
        if (out_sample_b !== 16'h0000) begin n_fail++; $display("FAIL none_out_b got %h exp 0000", out_sample_b); end
        if (pipe_sample !== 16'h4444) begin n_fail++; $display("FAIL none_pipe_sample got %h exp 4444", pipe_sample); end
      end
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid_wait();
    in_sample_valid = 1'b1;
    in_sample       = 16'h0600;
    active_a        = 1'b1;
    active_b        = 1'b1;
    step();
    in_sample       = 16'h0601;
    step();
    in_sample_valid = 1'b0;
    n_checks += 2;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_setup_busy got %b exp 1", busy); end
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL rst_setup_overrun got %b exp 1", overrun); end
    #2 reset = 1'b1;
    #1;
    n_checks += 3;
    if ({busy, overrun, out_samples_valid, pipe_a_start, pipe_b_start, timeout_a, timeout_b} !== 7'b0) begin
      n_fail++; $display("FAIL rst_async_ctrl got %b exp 0", {busy, overrun, out_samples_valid, pipe_a_start, pipe_b_start, timeout_a, timeout_b});
    end
    if (pipe_sample !== 16'h0000) begin n_fail++; $display("FAIL rst_async_pipe_sample got %h exp 0000", pipe_sample); end
    if ({out_sample_a, out_sample_b} !== 32'h0) begin n_fail++; $display("FAIL rst_async_out got %h exp 0", {out_sample_a, out_sample_b}); end
    step();
    reset         = 1'b0;
    pipe_a_done   = 1'b1;
    pipe_a_result = 16'h7777;
    pipe_b_done   = 1'b1;
    pipe_b_result = 16'h8888;
    step();
    pipe_a_done = 1'b0;
    pipe_b_done = 1'b0;
    step();
    n_checks += 2;
    if ({busy, out_samples_valid} !== 2'b00) begin n_fail++; $display("FAIL rst_late_done got %b exp 00", {busy, out_samples_valid}); end
    if (out_sample_a !== 16'h0000) begin n_fail++; $display("FAIL rst_late_out_a got %h exp 0000", out_sample_a); end
    for (int k = 0; k <= 3; k++) begin
      in_sample_valid = (k == 0);
      in_sample       = 16'h0900;
      active_a        = 1'b1;
      active_b        = 1'b1;
      pipe_a_done     = (k == 1);
      pipe_a_result   = 16'h0111;
      pipe_b_done     = (k == 1);
      pipe_b_result   = 16'h0222;
      n_checks += 2;
      if (pipe_a_start !== (k == 1)) begin n_fail++; $display("FAIL rst_next_start k=%0d got %b exp %b", k, pipe_a_start, (k == 1)); end
      if (out_samples_valid !== (k == 2)) begin n_fail++; $display("FAIL rst_next_valid k=%0d got %b exp %b", k, out_samples_valid, (k == 2)); end
      if (k == 2) begin
        n_checks += 2;
        if (out_sample_a !== 16'h0111) begin n_fail++; $display("FAIL rst_next_out_a got %h exp 0111", out_sample_a); end
        if (out_sample_b !== 16'h0222) begin n_fail++; $display("FAIL rst_next_out_b got %h exp 0222", out_sample_b); end
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    idle_inputs();
    test_reset();
    test_both_active();
    test_a_only();
    test_timeout();
    test_overrun();
    test_none_active();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
